add_sub_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational Add_Sub carry-look-ahead adder between NUM_REQ requesters in the ODE-solver datapath, such as the integrator stage update units.
- Accepts at most one add/subtract request at a time.
- Registers operands and drives the shared adder.
- Returns the result, overflow flag and requester ID on a valid/ready response channel.
- Subtraction is performed by two's-complement negation of B ahead of the adder; the adder's carry-in stays 0.

---
 rtl/add_sub_pkg.sv | 38 +++
 rtl/add_sub_arbiter_if.sv | 34 +++
 rtl/add_sub_arbiter_add_sub.sv | 47 ++++
 rtl/add_sub_arbiter.sv | 120 ++++++++++++
 tb/tb_add_sub_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub arbiter slice.
//   state_e  : arbiter FSM encoding (IDLE, EXEC, RESP)
//   MAX_REQ  : widest requester vector rr_pick() handles
//   MIN_VAL  : most-negative value, MSB-aligned in 64 bits; slice the top
//              DATA_WIDTH bits to get -2^(DATA_WIDTH-1) at any width
//   rr_pick  : round-robin search starting just after ptr
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_REQ = 8;
  localparam logic [63:0] MIN_VAL = 64'h8000_0000_0000_0000;

  // First set bit of valid at ptr+1, ptr+2, ... modulo n. Returns 0 when
  // nothing is valid; callers qualify with |valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/add_sub_arbiter_if.sv
// Request/response bus between NUM_REQ requesters and the add/sub arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed signed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_sub             : 1 = A-B, 0 = A+B
//   rsp_*               : single valid/ready response channel with owner id
// master = requester side, slave = arbiter side.
interface add_sub_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_sub;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_result;
  logic                          rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

endinterface

// File: rtl/add_sub_arbiter_add_sub.sv
// Add_Sub: combinational carry-look-ahead adder built from 4-bit CLA slices,
// slices chained through their group generate/propagate.
//   a, b : operands (DATA_WIDTH, multiple of 4)
//   cin  : carry in
//   sum  : a + b + cin, wrapped
//   ovf  : signed overflow (carry into MSB xor carry out of MSB)
module Add_Sub #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  ovf
);

  localparam int unsigned NSL = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar s = 0; s < NSL; s++) begin : g_slice
    localparam int unsigned B = 4 * s;
    logic gg;
    logic pg;

    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);

    assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
              | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pg = p[B+3] & p[B+2] & p[B+1] & p[B];

    assign c[B+4] = gg | (pg & c[B]);
  end

  assign sum = p ^ c[DATA_WIDTH-1:0];
  assign ovf = c[DATA_WIDTH] ^ c[DATA_WIDTH-1];

endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin scheduler sharing one Add_Sub adder among
// NUM_REQ requesters, one operation in flight at a time.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (discards any in-flight operation)
//   bus   : add_sub_arbiter_if slave (request handshakes + response channel)
//   busy  : high in EXEC or RESP
// Subtraction negates B before the adder; adder carry-in is always 0.
module add_sub_arbiter
  import add_sub_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  add_sub_arbiter_if.slave      bus,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] MIN = MIN_VAL[63 -: DATA_WIDTH];
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_e                state;
  logic [ID_W-1:0]       rr_ptr;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_sub;
  logic                  op_b_min;
  logic [ID_W-1:0]       op_id;

  logic [MAX_REQ-1:0]    valid8;
  logic [2:0]            pick;
  logic [ID_W-1:0]       g;
  logic                  grant_window;
  logic                  do_grant;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] nxt_b;

  logic [DATA_WIDTH-1:0] sum;
  logic                  add_ovf;

  // Grant selection. rsp_ready feeds req_ready combinationally so a new
  // operation can start in the same cycle the previous response drains.
  always_comb begin
    valid8                = '0;
    valid8[NUM_REQ-1:0]   = bus.req_valid;
    pick                  = rr_pick(valid8, 3'(rr_ptr), NUM_REQ);
    g                     = ID_W'(pick);
    grant_window          = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    do_grant              = rst_n && grant_window && (|bus.req_valid);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = do_grant && (g == ID_W'(i));
    end
    sel_a = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
    sel_b = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
    nxt_b = bus.req_sub[g] ? (~sel_b + ONE) : sel_b;
  end

  assign busy = (state == EXEC) || (state == RESP);

  Add_Sub #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_add_sub (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= ID_W'(NUM_REQ - 1);
      op_a             <= '0;
      op_b             <= '0;
      op_sub           <= 1'b0;
      op_b_min         <= 1'b0;
      op_id            <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      if (do_grant) begin
        op_a     <= sel_a;
        op_b     <= nxt_b;
        op_sub   <= bus.req_sub[g];
        op_b_min <= (sel_b == MIN);
        op_id    <= g;
        rr_ptr   <= g;
      end
      case (state)
        IDLE: begin
          if (do_grant) state <= EXEC;
        end
        EXEC: begin
          bus.rsp_result   <= sum;
          // -MIN wraps back to MIN, so the adder's own overflow is wrong for
          // that case; A - MIN overflows exactly when A is non-negative.
          bus.rsp_overflow <= (op_sub && op_b_min) ? ~op_a[DATA_WIDTH-1] : add_ovf;
          bus.rsp_id       <= op_id;
          bus.rsp_valid    <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= do_grant ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
module tb_add_sub_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    int unsigned idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  logic busy;

  int unsigned n_vec;
  int unsigned n_err;

  add_sub_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  add_sub_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .ID_W      (IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [15:0] a, input logic [15:0] b,
                         input logic sub);
    bus.req_valid[i]          = 1'b1;
    bus.req_a[i*DW +: DW]     = a;
    bus.req_b[i*DW +: DW]     = b;
    bus.req_sub[i]            = sub;
  endtask

  vec_t vecs[12];
  logic [15:0] ra;
  logic [15:0] rb;
  logic [15:0] held_res;
  int unsigned exp_id;

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{0, 16'd100,  16'hFFE2, 1'b0, 16'd70,   1'b0};
    vecs[1]  = '{2, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1};
    vecs[2]  = '{2, 16'h0005, 16'h8000, 1'b1, 16'h8005, 1'b1};
    vecs[3]  = '{2, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0};
    vecs[4]  = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5]  = '{3, 16'h4000, 16'h3FFF, 1'b0, 16'h7FFF, 1'b0};
    vecs[6]  = '{1, 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b0};
    vecs[7]  = '{3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
    vecs[8]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
    vecs[10] = '{2, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0};
    vecs[11] = '{3, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_result", 32'(bus.rsp_result), 0);
    check("rst_rsp_overflow", 32'(bus.rsp_overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven single operations
    for (int v = 0; v < 12; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sub);
      bus.rsp_ready = 1'b1;
      #1;
      check($sformatf("v%0d_req_ready", v), 32'(bus.req_ready), 32'(1) << vecs[v].idx);
      tick();
      bus.req_valid = '0;
      #1;
      check($sformatf("v%0d_exec_ready", v), 32'(bus.req_ready), 0);
      check($sformatf("v%0d_exec_valid", v), 32'(bus.rsp_valid), 0);
      check($sformatf("v%0d_exec_busy", v), 32'(busy), 1);
      tick();
      check($sformatf("v%0d_rsp_valid", v), 32'(bus.rsp_valid), 1);
      check($sformatf("v%0d_rsp_id", v), 32'(bus.rsp_id), vecs[v].idx);
      check($sformatf("v%0d_rsp_result", v), 32'(bus.rsp_result), 32'(vecs[v].res));
      check($sformatf("v%0d_rsp_overflow", v), 32'(bus.rsp_overflow), 32'(vecs[v].ovf));
      tick();
      check($sformatf("v%0d_idle_valid", v), 32'(bus.rsp_valid), 0);
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 0);
    end

    // Round robin: last grant was requester 3, so order is 0,1,2,3,0,1
    for (int unsigned i = 0; i < NR; i++) begin
      ra = 16'h0100 * 16'(i + 1);
      rb = 16'(i + 1);
      set_req(i, ra, rb, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_id = k % NR;
      check($sformatf("rr%0d_req_ready", k), 32'(bus.req_ready), 32'(1) << exp_id);
      tick();
      check($sformatf("rr%0d_exec_valid", k), 32'(bus.rsp_valid), 0);
      tick();
      check($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 1);
      check($sformatf("rr%0d_rsp_id", k), 32'(bus.rsp_id), exp_id);
      check($sformatf("rr%0d_rsp_result", k), 32'(bus.rsp_result),
            32'(16'h0100 * 16'(exp_id + 1) + 16'(exp_id + 1)));
    end
    bus.req_valid = '0;
    tick();
    check("rr_idle_valid", 32'(bus.rsp_valid), 0);

    // Backpressure: response held for 5 cycles, then req1 granted as it drains
    set_req(0, 16'h0010, 16'h0003, 1'b1);
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    set_req(1, 16'h0200, 16'h0100, 1'b1);
    held_res = 16'h000D;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 1);
      check($sformatf("bp%0d_rsp_result", c), 32'(bus.rsp_result), 32'(held_res));
      check($sformatf("bp%0d_rsp_id", c), 32'(bus.rsp_id), 0);
      check($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("bp_gap_valid", 32'(bus.rsp_valid), 0);
    tick();
    check("bp_req1_valid", 32'(bus.rsp_valid), 1);
    check("bp_req1_id", 32'(bus.rsp_id), 1);
    check("bp_req1_result", 32'(bus.rsp_result), 32'h0100);
    tick();

    // Reset during EXEC: no response, pointer back to NUM_REQ-1
    set_req(2, 16'h0001, 16'h0001, 1'b0);
    #1;
    check("rm_req_ready", 32'(bus.req_ready), 32'h4);
    tick();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #1;
    check("rm_rst_req_ready", 32'(bus.req_ready), 0);
    tick();
    check("rm_rst_valid", 32'(bus.rsp_valid), 0);
    check("rm_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    check("rm_after_valid0", 32'(bus.rsp_valid), 0);
    tick();
    check("rm_after_valid1", 32'(bus.rsp_valid), 0);
    for (int unsigned i = 0; i < NR; i++) begin
      set_req(i, 16'h0020, 16'(i), 1'b0);
    end
    #1;
    check("rm_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    check("rm_rsp_valid", 32'(bus.rsp_valid), 1);
    check("rm_rsp_id", 32'(bus.rsp_id), 0);
    check("rm_rsp_result", 32'(bus.rsp_result), 32'h0020);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
